// File: rtl/mips_cpu_lsu_if.sv
// Core-request / Avalon-MM bundle for the MIPS load/store unit.
// slave = LSU side, master = core + bus side. Optional fields under MIPS_LSU_UNALIGNED_EN.
interface mips_cpu_lsu_if #(parameter int ADDR_W = 32);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
`ifdef MIPS_LSU_UNALIGNED_EN
   logic              req_right;
   logic [31:0]       req_merge;
`endif
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic [ADDR_W-1:0] address;
   logic              read;
   logic              write;
   logic              waitrequest;
   logic [31:0]       writedata;
   logic [3:0]        byteenable;
   logic [31:0]       readdata;

`ifdef MIPS_LSU_UNALIGNED_EN
   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
             req_right, req_merge, waitrequest, readdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
             address, read, write, writedata, byteenable
   );
   modport master (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
             req_right, req_merge, waitrequest, readdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             address, read, write, writedata, byteenable
   );
`else
   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
             waitrequest, readdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
             address, read, write, writedata, byteenable
   );
   modport master (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
             waitrequest, readdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             address, read, write, writedata, byteenable
   );
`endif
endinterface

// File: rtl/mips_cpu_lsu.sv
// Load/store unit: one core access at a time onto Avalon-MM, with lane steering and load extension.
// Define MIPS_LSU_UNALIGNED_EN to enable LWL/LWR (size 3) merging loads.
module mips_cpu_lsu #(
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 0
) (
   input  logic               clk,
   input  logic               reset,
   mips_cpu_lsu_if.slave      bus_if
);
   typedef enum logic [2:0] {S_IDLE, S_BUS, S_CAPT, S_RESP, S_ERR} state_t;

   state_t            state_q, state_d;
   logic              wr_q, sgn_q;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wd_q, wd_d;
   logic [31:0]       rdata_q, fmt_d;
   logic [31:0]       tmo_q;
   logic              accept, bad_req, tmo_hit;
`ifdef MIPS_LSU_UNALIGNED_EN
   logic              right_q;
   logic [31:0]       merge_q;
`endif

   assign accept  = (state_q == S_IDLE) && bus_if.req_valid;
   assign tmo_hit = (TIMEOUT_CYC != 0) && bus_if.waitrequest && (tmo_q == 32'(TIMEOUT_CYC - 1));

   always_comb begin
      bad_req = 1'b0;
      case (bus_if.req_size)
         2'd1:    bad_req = bus_if.req_addr[0];
         2'd2:    bad_req = |bus_if.req_addr[1:0];
`ifdef MIPS_LSU_UNALIGNED_EN
         2'd3:    bad_req = bus_if.req_write;
`else
         2'd3:    bad_req = 1'b1;
`endif
         default: bad_req = 1'b0;
      endcase
   end

   always_comb begin
      be_d = 4'b1111;
      wd_d = bus_if.req_wdata;
      case (bus_if.req_size)
         2'd0: begin
            be_d = 4'b0001 << bus_if.req_addr[1:0];
            wd_d = {4{bus_if.req_wdata[7:0]}};
         end
         2'd1: begin
            be_d = bus_if.req_addr[1] ? 4'b1100 : 4'b0011;
            wd_d = {2{bus_if.req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Load formatting from the captured lane; k = addr[1:0], and 3-k is simply ~k.
   always_comb begin
      logic [31:0] lane;
      logic [4:0]  sh_r, sh_l;
      sh_r  = {addr_q[1:0], 3'b000};
      sh_l  = {~addr_q[1:0], 3'b000};
      lane  = bus_if.readdata >> sh_r;
      fmt_d = 32'd0;
      case (size_q)
         2'd0: fmt_d = {{24{sgn_q & lane[7]}}, lane[7:0]};
         2'd1: fmt_d = {{16{sgn_q & lane[15]}}, lane[15:0]};
         2'd2: fmt_d = bus_if.readdata;
`ifdef MIPS_LSU_UNALIGNED_EN
         2'd3: fmt_d = right_q
                 ? (lane | (merge_q & ~(32'hFFFF_FFFF >> sh_r)))
                 : ((bus_if.readdata << sh_l) | (merge_q & ((32'd1 << sh_l) - 32'd1)));
`endif
         default: fmt_d = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept) state_d = bad_req ? S_ERR : S_BUS;
         S_BUS: begin
            if (!bus_if.waitrequest) state_d = wr_q ? S_RESP : S_CAPT;
            else if (tmo_hit)        state_d = S_ERR;
         end
         S_CAPT:  state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus_if.req_ready  = (state_q == S_IDLE);
      bus_if.read       = (state_q == S_BUS) && !wr_q;
      bus_if.write      = (state_q == S_BUS) && wr_q;
      bus_if.resp_valid = (state_q == S_RESP) || (state_q == S_ERR);
      bus_if.resp_err   = (state_q == S_ERR);
      bus_if.resp_rdata = (state_q == S_RESP) ? rdata_q : 32'd0;
      bus_if.address    = {addr_q[ADDR_W-1:2], 2'b00};
      bus_if.byteenable = be_q;
      bus_if.writedata  = wd_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q    <= 1'b0;
         sgn_q   <= 1'b0;
         size_q  <= 2'd0;
         addr_q  <= '0;
         be_q    <= 4'd0;
         wd_q    <= 32'd0;
         rdata_q <= 32'd0;
         tmo_q   <= 32'd0;
`ifdef MIPS_LSU_UNALIGNED_EN
         right_q <= 1'b0;
         merge_q <= 32'd0;
`endif
      end else begin
         if (accept) begin
            wr_q    <= bus_if.req_write;
            sgn_q   <= bus_if.req_signed;
            size_q  <= bus_if.req_size;
            addr_q  <= bus_if.req_addr;
            be_q    <= be_d;
            wd_q    <= wd_d;
            rdata_q <= 32'd0;
            tmo_q   <= 32'd0;
`ifdef MIPS_LSU_UNALIGNED_EN
            right_q <= bus_if.req_right;
            merge_q <= bus_if.req_merge;
`endif
         end else if (state_q == S_BUS && bus_if.waitrequest) begin
            tmo_q <= tmo_q + 32'd1;
         end
         if (state_q == S_CAPT) rdata_q <= fmt_d;
      end
   end
endmodule
